// File: rtl/console_writer.sv
// console_writer: owns the character VRAM write port, tracks the cursor and blanks the screen.
// Define CONSOLE_LINE_CLEAR_EN to blank each newly entered row on a row advance.
module console_writer #(
    parameter int size = 16
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    input  logic        clear_i,
    output logic        we_vram,
    output logic [12:0] addr_vram,
    output logic [7:0]  data_vram,
    output logic [6:0]  cursor_x,
    output logic [6:0]  cursor_y,
    output logic        busy_o
);

    localparam int COLS  = 640 / size;
    localparam int ROWS  = 480 / size;
    localparam int TOTAL = COLS * ROWS;

    localparam logic [12:0] COLS13  = 13'(COLS);
    localparam logic [12:0] TOTAL13 = 13'(TOTAL);
    localparam logic [6:0]  LASTCOL = 7'(COLS - 1);
    localparam logic [6:0]  LASTROW = 7'(ROWS - 1);
    localparam logic [7:0]  BLANK   = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1
`ifdef CONSOLE_LINE_CLEAR_EN
        ,
        S_CLEAR_LINE = 2'd2
`endif
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [12:0] r_cnt;
    logic [6:0]  r_cx;
    logic [6:0]  r_cy;
    logic        r_we;
    logic [12:0] r_addr;
    logic [7:0]  r_data;
    logic        r_ready;
    logic        r_busy;

    logic [12:0] w_cnt_nx;
    logic [6:0]  w_cx_nx;
    logic [6:0]  w_cy_nx;
    logic        w_we_nx;
    logic [12:0] w_addr_nx;
    logic [7:0]  w_data_nx;
    logic        w_ready_nx;
    logic        w_busy_nx;

    logic        w_print;
    logic        w_lf;
    logic        w_cr;
    logic        w_bs;
    logic        w_last_col;
    logic        w_row_adv;
    logic        w_accept;
    logic [6:0]  w_cy_adv;
    logic [12:0] w_cur_addr;

    assign w_print    = (char_i >= 8'h20) && (char_i <= 8'h7E);
    assign w_lf       = (char_i == 8'h0A);
    assign w_cr       = (char_i == 8'h0D);
    assign w_bs       = (char_i == 8'h08);
    assign w_last_col = (r_cx == LASTCOL);
    assign w_row_adv  = w_lf || (w_print && w_last_col);
    assign w_accept   = char_valid_i && r_ready;
    assign w_cy_adv   = (r_cy == LASTROW) ? 7'd0 : r_cy + 7'd1;
    assign w_cur_addr = 13'(r_cy) * COLS13 + 13'(r_cx);

`ifdef CONSOLE_LINE_CLEAR_EN
    logic [12:0] w_line_addr;
    // Cursor already points at the new row while its line is blanked.
    assign w_line_addr = 13'(r_cy) * COLS13 + r_cnt;
`endif

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (clear_i) begin
                    w_state_nx = S_CLEAR;
                end
`ifdef CONSOLE_LINE_CLEAR_EN
                else if (w_accept && w_row_adv) begin
                    w_state_nx = S_CLEAR_LINE;
                end
`endif
            end
            S_CLEAR: begin
                if (r_cnt == TOTAL13) begin
                    w_state_nx = S_IDLE;
                end
            end
`ifdef CONSOLE_LINE_CLEAR_EN
            S_CLEAR_LINE: begin
                if (clear_i) begin
                    w_state_nx = S_CLEAR;
                end else if (r_cnt == COLS13) begin
                    w_state_nx = S_IDLE;
                end
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_we_nx    = 1'b0;
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        w_cnt_nx   = r_cnt;
        w_cx_nx    = r_cx;
        w_cy_nx    = r_cy;
        w_ready_nx = 1'b0;
        w_busy_nx  = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_ready_nx = 1'b1;
                w_busy_nx  = 1'b0;
                // A full clear writes address 0 on the edge it is seen.
                if (clear_i) begin
                    w_we_nx    = 1'b1;
                    w_addr_nx  = 13'd0;
                    w_data_nx  = BLANK;
                    w_cnt_nx   = 13'd1;
                    w_ready_nx = 1'b0;
                    w_busy_nx  = 1'b1;
                end else if (w_accept) begin
                    unique case (1'b1)
                        w_print: begin
                            w_we_nx   = 1'b1;
                            w_addr_nx = w_cur_addr;
                            w_data_nx = char_i;
                            w_cx_nx   = w_last_col ? 7'd0 : r_cx + 7'd1;
                            if (w_last_col) begin
                                w_cy_nx = w_cy_adv;
                            end
                        end
                        w_lf: begin
                            w_cx_nx = 7'd0;
                            w_cy_nx = w_cy_adv;
                        end
                        w_cr: w_cx_nx = 7'd0;
                        w_bs: begin
                            if (r_cx != 7'd0) begin
                                w_cx_nx = r_cx - 7'd1;
                            end
                        end
                        default: ;
                    endcase
`ifdef CONSOLE_LINE_CLEAR_EN
                    if (w_row_adv) begin
                        w_cnt_nx   = 13'd0;
                        w_ready_nx = 1'b0;
                        w_busy_nx  = 1'b1;
                    end
`endif
                end
            end
            S_CLEAR: begin
                if (r_cnt == TOTAL13) begin
                    w_cx_nx    = 7'd0;
                    w_cy_nx    = 7'd0;
                    w_ready_nx = 1'b1;
                    w_busy_nx  = 1'b0;
                end else begin
                    w_we_nx   = 1'b1;
                    w_addr_nx = r_cnt;
                    w_data_nx = BLANK;
                    w_cnt_nx  = r_cnt + 13'd1;
                end
            end
`ifdef CONSOLE_LINE_CLEAR_EN
            S_CLEAR_LINE: begin
                if (clear_i) begin
                    w_we_nx   = 1'b1;
                    w_addr_nx = 13'd0;
                    w_data_nx = BLANK;
                    w_cnt_nx  = 13'd1;
                end else if (r_cnt == COLS13) begin
                    w_ready_nx = 1'b1;
                    w_busy_nx  = 1'b0;
                end else begin
                    w_we_nx   = 1'b1;
                    w_addr_nx = w_line_addr;
                    w_data_nx = BLANK;
                    w_cnt_nx  = r_cnt + 13'd1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 13'd0;
            r_cx    <= 7'd0;
            r_cy    <= 7'd0;
            r_we    <= 1'b0;
            r_addr  <= 13'd0;
            r_data  <= 8'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_nx;
            r_cx    <= w_cx_nx;
            r_cy    <= w_cy_nx;
            r_we    <= w_we_nx;
            r_addr  <= w_addr_nx;
            r_data  <= w_data_nx;
            r_ready <= w_ready_nx;
            r_busy  <= w_busy_nx;
        end
    end

    assign char_ready_o = r_ready;
    assign we_vram      = r_we;
    assign addr_vram    = r_addr;
    assign data_vram    = r_data;
    assign cursor_x     = r_cx;
    assign cursor_y     = r_cy;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer: queue-based console model checked every cycle plus directed literal checks.
// Works with or without CONSOLE_LINE_CLEAR_EN defined.
module tb_console_writer;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int TOTAL = 1200;

    logic        px_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  char_i = 8'd0;
    logic        char_valid_i = 1'b0;
    logic        char_ready_o;
    logic        clear_i = 1'b0;
    logic        we_vram;
    logic [12:0] addr_vram;
    logic [7:0]  data_vram;
    logic [6:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic        busy_o;

    console_writer #(.size(16)) dut (
        .px_clk       (px_clk),
        .rst_n        (rst_n),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .clear_i      (clear_i),
        .we_vram      (we_vram),
        .addr_vram    (addr_vram),
        .data_vram    (data_vram),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .busy_o       (busy_o)
    );

    always #5 px_clk = ~px_clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s actual=%0h required=%0h t=%0t",
                         nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s timeout t=%0t", nm, $time);
    endtask

    // Model: pending blank writes queue, one popped per cycle.
    logic [12:0] mq[$];
    int          m_kind;
    bit          m_we;
    logic [12:0] m_addr;
    logic [7:0]  m_data;
    bit          m_ready;
    bit          m_busy;
    int          m_cx;
    int          m_cy;

    function automatic void m_fill_full();
        mq.delete();
        for (int i = 0; i < TOTAL; i++) mq.push_back(13'(i));
        m_kind = 1;
    endfunction

    function automatic void m_pop();
        m_addr  = mq.pop_front();
        m_data  = 8'h20;
        m_we    = 1'b1;
        m_ready = 1'b0;
        m_busy  = 1'b1;
    endfunction

    function automatic void m_reset();
        m_fill_full();
        m_we = 0; m_addr = 0; m_data = 0;
        m_ready = 0; m_busy = 1;
        m_cx = 0; m_cy = 0;
    endfunction

    function automatic void m_row_adv();
        m_cy = (m_cy == ROWS - 1) ? 0 : m_cy + 1;
`ifdef CONSOLE_LINE_CLEAR_EN
        mq.delete();
        for (int i = 0; i < COLS; i++) mq.push_back(13'(m_cy * COLS + i));
        m_kind  = 2;
        m_ready = 0;
        m_busy  = 1;
`endif
    endfunction

    function automatic void m_char(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_we   = 1;
            m_addr = 13'(m_cy * COLS + m_cx);
            m_data = c;
            if (m_cx == COLS - 1) begin
                m_cx = 0;
                m_row_adv();
            end else begin
                m_cx++;
            end
        end else if (c == 8'h0A) begin
            m_cx = 0;
            m_row_adv();
        end else if (c == 8'h0D) begin
            m_cx = 0;
        end else if (c == 8'h08) begin
            if (m_cx > 0) m_cx--;
        end
    endfunction

    function automatic void m_step();
        m_we = 0;
        if (mq.size() != 0) begin
            if (clear_i && m_kind == 2) m_fill_full();
            m_pop();
        end else if (m_kind != 0) begin
            if (clear_i && m_kind == 2) begin
                m_fill_full();
                m_pop();
            end else begin
                if (m_kind == 1) begin
                    m_cx = 0;
                    m_cy = 0;
                end
                m_kind  = 0;
                m_ready = 1;
                m_busy  = 0;
            end
        end else begin
            m_ready = 1;
            m_busy  = 0;
            if (clear_i) begin
                m_fill_full();
                m_pop();
            end else if (char_valid_i) begin
                m_char(char_i);
            end
        end
    endfunction

    always @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else m_step();
    end

    always @(negedge px_clk) begin
        chk("we_vram", 32'(we_vram), 32'(m_we));
        chk("addr_vram", 32'(addr_vram), 32'(m_addr));
        chk("data_vram", 32'(data_vram), 32'(m_data));
        chk("char_ready_o", 32'(char_ready_o), 32'(m_ready));
        chk("busy_o", 32'(busy_o), 32'(m_busy));
        chk("cursor_x", 32'(cursor_x), 32'(m_cx));
        chk("cursor_y", 32'(cursor_y), 32'(m_cy));
    end

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        char_i = c;
        char_valid_i = 1'b1;
        while (char_ready_o !== 1'b1 && n < 3000) begin
            @(negedge px_clk);
            n++;
        end
        if (n >= 3000) timeout("send");
        @(negedge px_clk);
        char_valid_i = 1'b0;
    endtask

    task automatic wait_idle(output int nw);
        int n;
        n = 0;
        nw = 0;
        while (char_ready_o !== 1'b1 && n < 5000) begin
            if (we_vram === 1'b1) nw++;
            @(negedge px_clk);
            n++;
        end
        if (n >= 5000) timeout("wait_idle");
    endtask

    initial begin
        int nw;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge px_clk);
        chk("rst_we", 32'(we_vram), 0);
        chk("rst_ready", 32'(char_ready_o), 0);
        chk("rst_busy", 32'(busy_o), 1);
        rst_n = 1'b1;
        wait_idle(nw);
        chk("boot_writes", nw, 1200);
        chk("boot_busy", 32'(busy_o), 0);
        chk("boot_cx", 32'(cursor_x), 0);
        chk("boot_cy", 32'(cursor_y), 0);

        send(8'h41);
        chk("A_we", 32'(we_vram), 1);
        chk("A_addr", 32'(addr_vram), 0);
        chk("A_data", 32'(data_vram), 32'h41);
        chk("A_cx", 32'(cursor_x), 1);
        send(8'h08);
        chk("bs1_we", 32'(we_vram), 0);
        chk("bs1_cx", 32'(cursor_x), 0);
        send(8'h08);
        chk("bs2_cx", 32'(cursor_x), 0);
        send(8'h01);
        send(8'h7F);
        chk("ign_we", 32'(we_vram), 0);
        chk("ign_cx", 32'(cursor_x), 0);

        for (int i = 0; i < 40; i++) send(8'h42);
        chk("B_addr", 32'(addr_vram), 39);
        chk("B_data", 32'(data_vram), 32'h42);
        chk("B_cx", 32'(cursor_x), 0);
        chk("B_cy", 32'(cursor_y), 1);
        wait_idle(nw);
`ifdef CONSOLE_LINE_CLEAR_EN
        chk("B_line_writes", nw, 41);
`else
        chk("B_line_writes", nw, 0);
`endif

        for (int i = 0; i < 28; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h70);
        chk("p_addr", 32'(addr_vram), 1164);
        chk("p_cx", 32'(cursor_x), 5);
        chk("p_cy", 32'(cursor_y), 29);
        send(8'h0A);
        chk("lf_we", 32'(we_vram), 0);
        chk("lf_cx", 32'(cursor_x), 0);
        chk("lf_cy", 32'(cursor_y), 0);
        wait_idle(nw);
`ifdef CONSOLE_LINE_CLEAR_EN
        chk("lf_line_writes", nw, 40);
`else
        chk("lf_line_writes", nw, 0);
`endif

        send(8'h78);
        send(8'h79);
        chk("xy_cx", 32'(cursor_x), 2);
        char_i = 8'h43;
        char_valid_i = 1'b1;
        clear_i = 1'b1;
        @(negedge px_clk);
        clear_i = 1'b0;
        chk("clr_first_addr", 32'(addr_vram), 0);
        chk("clr_first_data", 32'(data_vram), 32'h20);
        chk("clr_ready", 32'(char_ready_o), 0);
        wait_idle(nw);
        chk("clr_writes", nw, 1200);
        chk("clr_cx", 32'(cursor_x), 0);
        chk("clr_cy", 32'(cursor_y), 0);
        @(negedge px_clk);
        char_valid_i = 1'b0;
        chk("C_we", 32'(we_vram), 1);
        chk("C_addr", 32'(addr_vram), 0);
        chk("C_data", 32'(data_vram), 32'h43);
        chk("C_cx", 32'(cursor_x), 1);

`ifdef CONSOLE_LINE_CLEAR_EN
        send(8'h0A);
        repeat (5) @(negedge px_clk);
        chk("cl_mid_busy", 32'(busy_o), 1);
        clear_i = 1'b1;
        @(negedge px_clk);
        clear_i = 1'b0;
        chk("abort_addr", 32'(addr_vram), 0);
        chk("abort_we", 32'(we_vram), 1);
        wait_idle(nw);
        chk("abort_writes", nw, 1200);
`endif

        clear_i = 1'b1;
        @(negedge px_clk);
        clear_i = 1'b0;
        repeat (10) @(negedge px_clk);
        @(posedge px_clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(we_vram), 0);
        chk("arst_addr", 32'(addr_vram), 0);
        chk("arst_busy", 32'(busy_o), 1);
        chk("arst_ready", 32'(char_ready_o), 0);
        @(negedge px_clk);
        rst_n = 1'b1;
        wait_idle(nw);
        chk("rerun_writes", nw, 1200);
        repeat (3) @(negedge px_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
